// File: rtl/gpr_sched_pkg.sv
// Shared types and width helpers for the GPR access scheduler.
package gpr_sched_pkg;

  localparam int DATA_W_DEF  = 24;
  localparam int NUM_GPR_DEF = 8;
  localparam int NUM_REQ_DEF = 4;

  // Index width for a bank of n GPRs (at least one bit)
  function automatic int gpr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index width for n requesters (at least one bit)
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;

  // One granted operation at the default bank geometry
  typedef struct packed {
    op_t                          op;
    logic [$clog2(NUM_GPR_DEF)-1:0] addr;
    logic [DATA_W_DEF-1:0]        wdata;
    logic [$clog2(NUM_REQ_DEF)-1:0] id;
  } issue_t;

endpackage

// File: rtl/gpr_rr_arbiter.sv
// Single-grant arbiter: round-robin from a pointer by default, or fixed
// priority (lowest index wins, no pointer port) when GPR_SCHED_FIXED_PRIO_EN
// is defined.
module gpr_rr_arbiter
  import gpr_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = req_idx_w(N)
) (
  input  logic [N-1:0]  req,
`ifndef GPR_SCHED_FIXED_PRIO_EN
  input  logic [IW-1:0] ptr,
`endif
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // First requester found, scanning upward from the start point and wrapping
  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
`ifdef GPR_SCHED_FIXED_PRIO_EN
      j = k;
`else
      j = (int'(ptr) + k) % N;
`endif
      if (req[j] && !gnt_vld) begin
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_access_scheduler.sv
// GPR bank access scheduler: one read or write grant per cycle, issued to the
// bank one cycle later (load strobes / C bus, or B-bus select), with read data
// returned the cycle after that.
// Optional build macro: GPR_SCHED_FIXED_PRIO_EN selects fixed-priority
// arbitration instead of round-robin.
module gpr_access_scheduler
  import gpr_sched_pkg::*;
#(
  parameter  int NUM_GPR = NUM_GPR_DEF,
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int GW      = gpr_idx_w(NUM_GPR),
  localparam int RW      = req_idx_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ-1:0][GW-1:0]     req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_GPR-1:0]             load_gpr,
  output logic [DATA_W-1:0]              c_bus,
  output logic [GW-1:0]                  b_sel,
  input  logic [DATA_W-1:0]              b_bus,
  output logic                           rd_valid,
  output logic [RW-1:0]                  rd_id,
  output logic [DATA_W-1:0]              rd_data
);

  // What the read-return stage needs to remember about the issued op
  typedef struct packed {
    op_t           op;
    logic [GW-1:0] addr;
    logic [RW-1:0] id;
  } iss_t;

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] gnt;
  logic [RW-1:0]      gnt_idx;
  logic               gnt_vld;
  iss_t               iss_d, iss_q;
  logic               iss_vld;
  logic               d_addr_ok, q_addr_ok;

  // No grants while stalled or held in reset
  assign req_eff   = (stall || !rst_n) ? '0 : req_valid;
  assign req_ready = gnt;

`ifdef GPR_SCHED_FIXED_PRIO_EN
  gpr_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_eff),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );
`else
  logic [RW-1:0] rr_ptr;

  gpr_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_eff),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Pointer moves past the winner; holds on idle or stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (gnt_vld)
      rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end
`endif

  // Pick out the winning requester's fields
  always_comb begin
    iss_d      = '0;
    iss_d.op   = req_wr[gnt_idx] ? OP_WR : OP_RD;
    iss_d.addr = req_addr[gnt_idx];
    iss_d.id   = gnt_idx;
  end

  // Indices past the end of a non-power-of-2 bank hit no register
  assign d_addr_ok = ({1'b0, iss_d.addr} < (GW+1)'(NUM_GPR));
  assign q_addr_ok = ({1'b0, iss_q.addr} < (GW+1)'(NUM_GPR));

  // Issue stage: drive the bank in the cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld  <= 1'b0;
      iss_q    <= '0;
      load_gpr <= '0;
      c_bus    <= '0;
      b_sel    <= '0;
    end else begin
      iss_vld  <= gnt_vld;
      load_gpr <= '0;
      if (gnt_vld) begin
        iss_q <= iss_d;
        if (iss_d.op == OP_WR) begin
          c_bus <= req_wdata[gnt_idx];
          if (d_addr_ok) load_gpr[iss_d.addr] <= 1'b1;
        end else begin
          b_sel <= iss_d.addr;
        end
      end
    end
  end

  // Return stage: capture the B bus at the end of the issue cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= iss_vld && (iss_q.op == OP_RD);
      if (iss_vld && (iss_q.op == OP_RD)) begin
        rd_id   <= iss_q.id;
        rd_data <= q_addr_ok ? b_bus : '0;
      end
    end
  end

endmodule

// File: tb/tb_gpr_access_scheduler.sv
// Scoreboard bench for gpr_access_scheduler (4 requesters, 8 GPRs, 24-bit).
// The bench models the GPR bank itself so reads observe committed writes.
module tb_gpr_access_scheduler;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 stall;
  logic [3:0]           req_valid, req_wr, req_ready;
  logic [3:0][2:0]      req_addr;
  logic [3:0][23:0]     req_wdata;
  logic [7:0]           load_gpr;
  logic [23:0]          c_bus, b_bus, rd_data;
  logic [2:0]           b_sel;
  logic                 rd_valid;
  logic [1:0]           rd_id;

  gpr_access_scheduler #(.NUM_GPR(8), .NUM_REQ(4), .DATA_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .load_gpr  (load_gpr),
    .c_bus     (c_bus),
    .b_sel     (b_sel),
    .b_bus     (b_bus),
    .rd_valid  (rd_valid),
    .rd_id     (rd_id),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // GPR bank driven by the scheduler's strobes
  logic [23:0] bank [8] = '{default: 24'h0};
  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (load_gpr[i]) bank[i] <= c_bus;
  assign b_bus = bank[b_sel];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected bank writes and read returns, tagged with due cycle
  typedef struct {int due; int addr; logic [23:0] d;} wexp_t;
  typedef struct {int due; logic [1:0] id; logic [23:0] d;} rexp_t;
  wexp_t       wq[$];
  rexp_t       rq[$];
  wexp_t       w_e;
  rexp_t       r_e;
  logic [23:0] m_gpr [8] = '{default: 24'h0};
  int          cyc;
  int          m_ptr;
  logic [3:0]  eg;
  int          gi;

  // Monitor: check due outputs, then predict this cycle's grant
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq.delete();
      rq.delete();
      m_ptr = 0;
      cyc   = 0;
    end else begin
      cyc++;
      if (wq.size() > 0 && wq[0].due == cyc) begin
        w_e = wq.pop_front();
        chk("load_gpr", load_gpr, 8'h1 << w_e.addr);
        chk("c_bus", c_bus, w_e.d);
        m_gpr[w_e.addr] = w_e.d;
      end else begin
        chk("load_idle", load_gpr, 8'h0);
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r_e = rq.pop_front();
        chk("rd_valid", rd_valid, 1);
        chk("rd_id", rd_id, r_e.id);
        chk("rd_data", rd_data, r_e.d);
      end else begin
        chk("rd_idle", rd_valid, 0);
      end
      eg = 4'h0;
      gi = 0;
      if (!stall)
        for (int k = 0; k < 4; k++) begin
          int j;
`ifdef GPR_SCHED_FIXED_PRIO_EN
          j = k;
`else
          j = (m_ptr + k) % 4;
`endif
          if (req_valid[j] && eg == 4'h0) begin
            eg[j] = 1'b1;
            gi    = j;
          end
        end
      chk("req_ready", req_ready, eg);
      if (eg != 4'h0) begin
        if (req_wr[gi]) wq.push_back('{cyc + 1, int'(req_addr[gi]), req_wdata[gi]});
        else            rq.push_back('{cyc + 2, 2'(gi), m_gpr[req_addr[gi]]});
        m_ptr = (gi + 1) % 4;
      end
    end
  end

  // Present one request and hold it until granted
  task automatic issue(input int id, input bit wr, input int addr, input logic [23:0] d);
    int n;
    req_valid[id] = 1'b1;
    req_wr[id]    = wr;
    req_addr[id]  = 3'(addr);
    req_wdata[id] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[id] && n < 50);
    if (!req_ready[id]) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_seq;
    int n;
    rst_n = 1'b0; stall = 1'b0;
    req_valid = 4'hF; req_wr = 4'h0; req_wdata = '0;
    for (int i = 0; i < 4; i++) req_addr[i] = 3'(i);

    // Reset state with every requester pending
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_load", load_gpr, 0);
    chk("rst_c_bus", c_bus, 0);
    chk("rst_b_sel", b_sel, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_id", rd_id, 0);
    chk("rst_rd_data", rd_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = 4'h0;
    repeat (3) @(posedge clk); #1;

    // Single write strobes exactly one cycle
    issue(1, 1'b1, 3, 24'hABCDEF);
    @(negedge clk);
    chk("wr_load", load_gpr, 8'b0000_1000);
    chk("wr_c_bus", c_bus, 24'hABCDEF);
    @(negedge clk);
    chk("wr_load_off", load_gpr, 0);
    @(posedge clk); #1;

    // Write then read of the same GPR on consecutive grants
    issue(0, 1'b1, 5, 24'h000123);
    issue(2, 1'b0, 5, 24'h0);
    @(negedge clk);
    chk("raw_b_sel", b_sel, 5);
    chk("raw_early", rd_valid, 0);
    @(negedge clk);
    chk("raw_valid", rd_valid, 1);
    chk("raw_id", rd_id, 2);
    chk("raw_data", rd_data, 24'h000123);
    @(posedge clk); #1;

    // Reset in the cycle after a write grant drops the write
    req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 3'd6; req_wdata[1] = 24'hDEAD01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[1] && n < 50);
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 4'h0;
    @(negedge clk);
    chk("midrst_load", load_gpr, 0);
    repeat (2) @(posedge clk); #1;
    chk("midrst_gpr6", bank[6], m_gpr[6]);
    rst_n = 1'b1;

    // All requesters pending: grant order from a fresh pointer
    req_wr = 4'h0;
    for (int i = 0; i < 4; i++) req_addr[i] = 3'(i);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
`ifdef GPR_SCHED_FIXED_PRIO_EN
      exp_seq = 4'b0001;
`else
      exp_seq = 4'b0001 << (k % 4);
`endif
      chk("rr_seq", req_ready, exp_seq);
    end
    @(posedge clk); #1 req_valid = 4'h0;
    repeat (3) @(posedge clk); #1;

    // Stall blocks new grants only; the earlier write still lands
    issue(0, 1'b1, 2, 24'h55AA55);
    stall = 1'b1;
    req_valid[3] = 1'b1; req_wr[3] = 1'b1; req_addr[3] = 3'd7; req_wdata[3] = 24'h777777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", req_ready, 0);
      if (k == 0) chk("stall_load", load_gpr, 8'b0000_0100);
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    chk("stall_release", req_ready, 4'b1000);
    @(posedge clk); #1 req_valid[3] = 1'b0;

    // Random single requests through the scoreboard
    for (int k = 0; k < 24; k++)
      issue($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 7), 24'($urandom));

    repeat (4) @(negedge clk);
    chk("wq_drain", wq.size(), 0);
    chk("rq_drain", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

endmodule
